iir_cfg_scheduler: RTL

//  Controller in front of iir_2nd_order_lookahead (NB=12). Owns the six coefficient buses.

---
 rtl/iir_cfg_scheduler.sv | 132 +++++++++++++
 1 files changed

// File: rtl/iir_cfg_scheduler.sv
// Coefficient/sample scheduler in front of a 2nd-order look-ahead IIR filter.
// Commits are applied safely: stall, drain, swap shadow->active, flush with zeros, mask flush results.
module iir_cfg_scheduler #(
  parameter int NB        = 12,
  parameter int FLUSH_LEN = 4,
  parameter int MAX_OUT   = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_addr,
  input  logic [NB-1:0] cfg_data,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  input  logic [NB-1:0] s_din,
  input  logic          s_vin,
  output logic          s_ready,
  output logic [NB-1:0] f_din,
  output logic          f_vin,
  input  logic [NB-1:0] f_dout,
  input  logic          f_vout,
  output logic [NB-1:0] m_dout,
  output logic          m_vout,
  output logic [NB-1:0] a2,
  output logic [NB-1:0] a3,
  output logic [NB-1:0] b0,
  output logic [NB-1:0] b1,
  output logic [NB-1:0] b2,
  output logic [NB-1:0] b3
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int FW = $clog2(FLUSH_LEN + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP, ST_FLUSH} state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   flush_cnt;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   mask_cnt, mask_nxt;
  logic [NB-1:0]   shadow [6];
  logic [NB-1:0]   active [6];
  logic            accept;

  assign s_ready  = (state == ST_RUN);
  assign cfg_busy = (state != ST_RUN);
  assign accept   = s_vin && s_ready;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (cfg_commit) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_cnt == '0 && !f_vin) state_nxt = ST_SWAP;
      ST_SWAP:  state_nxt = ST_FLUSH;
      ST_FLUSH: if (flush_cnt == FW'(FLUSH_LEN - 1)) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_SWAP)       flush_cnt <= '0;
      else if (state == ST_FLUSH) flush_cnt <= flush_cnt + FW'(1);
    end
  end

  // Flush loads accumulate so a late commit cannot lose masking of outstanding zero samples.
  always_comb begin
    mask_nxt = mask_cnt;
    if (f_vout && mask_cnt != '0) mask_nxt = mask_nxt - CW'(1);
    if (state == ST_SWAP)         mask_nxt = mask_nxt + CW'(FLUSH_LEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt  <= '0;
      mask_cnt <= '0;
    end else begin
      mask_cnt <= mask_nxt;
      case ({f_vin, f_vout})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // NOTE: the coefficient arrays are only twelve words, so they are reset like ordinary flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (state == ST_RUN && cfg_we && cfg_addr < 3'd6) shadow[cfg_addr] <= cfg_data;
      if (state == ST_SWAP) begin
        for (int i = 0; i < 6; i++) active[i] <= shadow[i];
      end
    end
  end

  // Zero samples are issued during the FLUSH cycles themselves, hence the look at state_nxt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_vin  <= 1'b0;
      f_din  <= '0;
      m_vout <= 1'b0;
      m_dout <= '0;
    end else begin
      f_vin <= (state_nxt == ST_FLUSH) || accept;
      if (state_nxt == ST_FLUSH) f_din <= '0;
      else if (accept)           f_din <= s_din;
      m_vout <= f_vout && (mask_cnt == '0);
      if (f_vout && mask_cnt == '0) m_dout <= f_dout;
    end
  end

  assign a2 = active[0];
  assign a3 = active[1];
  assign b0 = active[2];
  assign b1 = active[3];
  assign b2 = active[4];
  assign b3 = active[5];

endmodule
